cache_write_buffer: RTL and testbench

//  Posted-write buffer between the cache and the RAM. Absorbs cache->memory write-backs into a FIFO
//  and drains them to the RAM write port one per cycle, so the cache never waits on RAM writes.
//  The cache's memory reads pass through to the RAM. Reads that match a pending write return the buffered data.

---
 rtl/memsys_pkg.sv | 20 ++
 rtl/wbuf_fifo.sv | 108 ++++++++++
 rtl/cache_write_buffer.sv | 196 +++++++++++++++++++
 tb/tb_cache_write_buffer.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memsys_pkg.sv
// ----------------------------------------------------------------------------
// memsys_pkg
// Shared widths and the write-buffer entry type for the cache/RAM memory
// subsystem.
//   ADDR_W        : RAM address width (64-byte RAM)
//   DATA_W        : RAM data width
//   wbuf_entry_t  : one posted-write slot {valid, adr, data}
// ----------------------------------------------------------------------------
package memsys_pkg;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 8;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] adr;
        logic [DATA_W-1:0] data;
    } wbuf_entry_t;

endpackage

// File: rtl/wbuf_fifo.sv
// ----------------------------------------------------------------------------
// wbuf_fifo
// Circular storage for posted writes: head/tail pointers, occupancy count,
// per-entry valid bits and address comparators for the write and read ports.
// Ports:
//   i_clk, i_rst_n       clock, asynchronous active-low reset
//   i_push               allocate a new entry at the tail
//   i_push_adr/_data     address/data of the pushed write (also the
//                        address compared for in-place updates)
//   i_pop                retire the head entry
//   i_upd, i_upd_idx     overwrite the data of an existing entry in place
//   i_upd_data           replacement data
//   i_rd_adr             read address for the forwarding lookup
//   o_count              number of valid entries (0..DEPTH)
//   o_head_adr/_data     contents of the head entry
//   o_wr_match           per-entry hit vector for i_push_adr, head excluded
//   o_rd_hit, o_rd_data  youngest valid entry matching i_rd_adr
// ----------------------------------------------------------------------------
module wbuf_fifo
    import memsys_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_push,
    input  logic [ADDR_W-1:0]          i_push_adr,
    input  logic [DATA_W-1:0]          i_push_data,
    input  logic                       i_pop,
    input  logic                       i_upd,
    input  logic [$clog2(DEPTH)-1:0]   i_upd_idx,
    input  logic [DATA_W-1:0]          i_upd_data,
    input  logic [ADDR_W-1:0]          i_rd_adr,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic [ADDR_W-1:0]          o_head_adr,
    output logic [DATA_W-1:0]          o_head_data,
    output logic [DEPTH-1:0]           o_wr_match,
    output logic                       o_rd_hit,
    output logic [DATA_W-1:0]          o_rd_data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wbuf_entry_t      r_mem [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    logic [PTR_W-1:0] w_idx;

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (i_upd) begin
                r_mem[i_upd_idx].data <= i_upd_data;
            end
            if (i_pop) begin
                r_mem[r_head].valid <= 1'b0;
                r_head              <= r_head + PTR_W'(1);
            end
            // A push never lands on the head being popped: pushes are only
            // allocated when the buffer is not full, so tail != head unless
            // the buffer is empty, in which case nothing is popped.
            if (i_push) begin
                r_mem[r_tail] <= '{valid: 1'b1, adr: i_push_adr, data: i_push_data};
                r_tail        <= r_tail + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(i_push) - CNT_W'(i_pop);
        end
    end

    assign o_count     = r_count;
    assign o_head_adr  = r_mem[r_head].adr;
    assign o_head_data = r_mem[r_head].data;

    // The head is always leaving on this edge whenever it is valid, so it is
    // never a candidate for an in-place update.
    always_comb begin
        o_wr_match = '0;
        for (int i = 0; i < DEPTH; i++) begin
            o_wr_match[i] = r_mem[i].valid && (r_mem[i].adr == i_push_adr)
                            && (PTR_W'(i) != r_head);
        end
    end

    // Walk from the oldest slot (tail-DEPTH) to the youngest (tail-1); the
    // last hit found is therefore the youngest matching entry.
    always_comb begin
        o_rd_hit  = 1'b0;
        o_rd_data = '0;
        w_idx     = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            w_idx = r_tail - PTR_W'(k);
            if (r_mem[w_idx].valid && (r_mem[w_idx].adr == i_rd_adr)) begin
                o_rd_hit  = 1'b1;
                o_rd_data = r_mem[w_idx].data;
            end
        end
    end

endmodule

// File: rtl/cache_write_buffer.sv
// ----------------------------------------------------------------------------
// cache_write_buffer
// Posted-write buffer between the cache and the RAM. Cache write-backs are
// absorbed into a FIFO and drained to the RAM write port one per cycle through
// a registered strobe. Cache reads pass through to the RAM, but a read that
// hits a pending write returns the buffered data (newest first).
// Build option:
//   WBUF_COALESCE_EN  when defined, a push that matches a queued entry (other
//                     than the head being drained) overwrites it in place,
//                     even while the buffer is full.
// Ports:
//   clk, reset                  clock, asynchronous active-low reset
//   wr_req_en/_adr/_data        cache write request
//   wr_full                     buffer full, allocating pushes are dropped
//   buf_empty                   nothing queued and no strobe in flight
//   rd_req_en/_adr              cache read request (combinational lookup)
//   rd_data, rd_fwd             read result and "came from buffer" flag
//   mem_write_enable/_adr/_data registered RAM write port
//   mem_read_enable/_adr        RAM read port (pass-through)
//   mem_read_data               RAM combinational read data
//   dbg_state                   FSM state (0 = IDLE, 1 = DRAIN)
// Handshake: a write is taken on the rising edge when wr_req_en is high and
// it either coalesces or wr_full is low; there is no back-pressure toward the
// RAM, so every queued entry leaves one per cycle.
// ----------------------------------------------------------------------------
module cache_write_buffer
    import memsys_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_req_en,
    input  logic [ADDR_W-1:0] wr_req_adr,
    input  logic [DATA_W-1:0] wr_req_data,
    output logic              wr_full,
    output logic              buf_empty,
    input  logic              rd_req_en,
    input  logic [ADDR_W-1:0] rd_req_adr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_fwd,
    output logic              mem_write_enable,
    output logic [ADDR_W-1:0] mem_write_adr,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_read_enable,
    output logic [ADDR_W-1:0] mem_read_adr,
    input  logic [DATA_W-1:0] mem_read_data,
    output logic [0:0]        dbg_state
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_DRAIN = 1'b1;

`ifdef WBUF_COALESCE_EN
    localparam bit COALESCE_EN = 1'b1;
`else
    localparam bit COALESCE_EN = 1'b0;
`endif

    logic [CNT_W-1:0]  w_count;
    logic [ADDR_W-1:0] w_head_adr;
    logic [DATA_W-1:0] w_head_data;
    logic [DEPTH-1:0]  w_wr_match;
    logic              w_fifo_hit;
    logic [DATA_W-1:0] w_fifo_data;
    logic              w_pop;
    logic              w_coal;
    logic              w_alloc;
    logic              w_accept;
    logic [PTR_W-1:0]  w_coal_idx;
    logic [0:0]        w_state_nxt;

    logic [0:0]        r_state;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_adr;
    logic [DATA_W-1:0] r_mem_data;

    // ------------------------------------------------------------------
    // Accept / allocate / coalesce decisions (all from registered state)
    // ------------------------------------------------------------------
    assign w_pop    = (w_count != '0);
    assign wr_full  = (w_count == CNT_W'(DEPTH));
    assign w_coal   = COALESCE_EN && wr_req_en && (|w_wr_match);
    // A full buffer drops an allocating push even if the head leaves on the
    // same edge.
    assign w_alloc  = wr_req_en && !w_coal && !wr_full;
    assign w_accept = w_coal || w_alloc;

    // With coalescing at most one entry per address exists, so any set bit
    // of the match vector identifies the entry to update.
    always_comb begin
        w_coal_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_wr_match[i]) begin
                w_coal_idx = PTR_W'(i);
            end
        end
    end

    wbuf_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk       (clk),
        .i_rst_n     (reset),
        .i_push      (w_alloc),
        .i_push_adr  (wr_req_adr),
        .i_push_data (wr_req_data),
        .i_pop       (w_pop),
        .i_upd       (w_coal),
        .i_upd_idx   (w_coal_idx),
        .i_upd_data  (wr_req_data),
        .i_rd_adr    (rd_req_adr),
        .o_count     (w_count),
        .o_head_adr  (w_head_adr),
        .o_head_data (w_head_data),
        .o_wr_match  (w_wr_match),
        .o_rd_hit    (w_fifo_hit),
        .o_rd_data   (w_fifo_data)
    );

    // ------------------------------------------------------------------
    // RAM write strobe register: the head moves here on every edge where
    // the FIFO is non-empty; address/data hold when nothing is popped.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mem_we   <= 1'b0;
            r_mem_adr  <= '0;
            r_mem_data <= '0;
        end else if (w_pop) begin
            r_mem_we   <= 1'b1;
            r_mem_adr  <= w_head_adr;
            r_mem_data <= w_head_data;
        end else begin
            r_mem_we   <= 1'b0;
        end
    end

    assign mem_write_enable = r_mem_we;
    assign mem_write_adr    = r_mem_adr;
    assign mem_write_data   = r_mem_data;
    assign mem_read_enable  = rd_req_en;
    assign mem_read_adr     = rd_req_adr;

    // ------------------------------------------------------------------
    // FSM: IDLE means nothing queued and no strobe in flight.
    // In DRAIN, an empty FIFO with no incoming write means no pop happens on
    // this edge, so after it both the FIFO and the strobe are clear.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept)            w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (!w_pop && !w_accept) w_state_nxt = ST_IDLE;
            default:                           w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    assign buf_empty = (r_state == ST_IDLE);
    assign dbg_state = r_state;

    // ------------------------------------------------------------------
    // Read forwarding, newest data first: the write being taken this cycle,
    // then the youngest queued entry, then the strobe register, then RAM.
    // ------------------------------------------------------------------
    always_comb begin
        rd_data = '0;
        rd_fwd  = 1'b0;
        if (rd_req_en) begin
            if (w_accept && (wr_req_adr == rd_req_adr)) begin
                rd_data = wr_req_data;
                rd_fwd  = 1'b1;
            end else if (w_fifo_hit) begin
                rd_data = w_fifo_data;
                rd_fwd  = 1'b1;
            end else if (r_mem_we && (r_mem_adr == rd_req_adr)) begin
                rd_data = r_mem_data;
                rd_fwd  = 1'b1;
            end else begin
                rd_data = mem_read_data;
            end
        end
    end

endmodule

// File: tb/tb_cache_write_buffer.sv
// ----------------------------------------------------------------------------
// tb_cache_write_buffer
// Drives directed and random cache traffic into cache_write_buffer, with a RAM
// model attached to its memory ports. A queue-based reference model predicts
// the RAM write stream, read results and status flags; a negedge monitor
// compares them against the DUT.
// ----------------------------------------------------------------------------
module tb_cache_write_buffer;

  localparam int DEPTH = 4;

`ifdef WBUF_COALESCE_EN
  localparam bit COAL = 1'b1;
`else
  localparam bit COAL = 1'b0;
`endif

  typedef struct {
    logic [5:0] adr;
    logic [7:0] data;
  } ent_t;

  logic       clk;
  logic       reset;
  logic       wr_req_en;
  logic [5:0] wr_req_adr;
  logic [7:0] wr_req_data;
  logic       wr_full;
  logic       buf_empty;
  logic       rd_req_en;
  logic [5:0] rd_req_adr;
  logic [7:0] rd_data;
  logic       rd_fwd;
  logic       mem_write_enable;
  logic [5:0] mem_write_adr;
  logic [7:0] mem_write_data;
  logic       mem_read_enable;
  logic [5:0] mem_read_adr;
  logic [7:0] mem_read_data;
  logic [0:0] dbg_state;

  // reference model state
  ent_t       mdl_q[$];
  logic [7:0] mdl_ram[64];
  bit         mdl_sv;
  logic [5:0] mdl_sa;
  logic [7:0] mdl_sd;

  // scoreboard queues
  logic [13:0] exp_wr_q[$];
  logic [8:0]  exp_rd_q[$];
  logic [2:0]  exp_st_q[$];

  logic [7:0] env_ram[64];
  int  total;
  int  bad;
  bit  mon_on;

  cache_write_buffer #(.DEPTH(DEPTH)) dut (
    .clk              (clk),
    .reset            (reset),
    .wr_req_en        (wr_req_en),
    .wr_req_adr       (wr_req_adr),
    .wr_req_data      (wr_req_data),
    .wr_full          (wr_full),
    .buf_empty        (buf_empty),
    .rd_req_en        (rd_req_en),
    .rd_req_adr       (rd_req_adr),
    .rd_data          (rd_data),
    .rd_fwd           (rd_fwd),
    .mem_write_enable (mem_write_enable),
    .mem_write_adr    (mem_write_adr),
    .mem_write_data   (mem_write_data),
    .mem_read_enable  (mem_read_enable),
    .mem_read_adr     (mem_read_adr),
    .mem_read_data    (mem_read_data),
    .dbg_state        (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- RAM attached to the DUT ----------------
  always @(posedge clk) begin
    if (mem_write_enable) env_ram[mem_write_adr] = mem_write_data;
  end
  assign mem_read_data = env_ram[mem_read_adr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [2:0]  st;
    logic [13:0] w;
    logic [8:0]  r;
    if (mon_on) begin
      st = 3'b000;
      if (exp_st_q.size() == 0) begin
        check("status_expected", 32'(exp_st_q.size()), 32'd1);
      end else begin
        st = exp_st_q.pop_front();
        check("mem_write_enable", 32'(mem_write_enable), 32'(st[2]));
        check("wr_full", 32'(wr_full), 32'(st[1]));
        check("buf_empty", 32'(buf_empty), 32'(st[0]));
      end
      if (mem_write_enable) begin
        if (exp_wr_q.size() == 0) begin
          check("unexpected_ram_write", 32'(exp_wr_q.size()), 32'd1);
        end else begin
          w = exp_wr_q.pop_front();
          check("ram_write_adr", 32'(mem_write_adr), 32'(w[13:8]));
          check("ram_write_data", 32'(mem_write_data), 32'(w[7:0]));
        end
      end else if (st[2] && exp_wr_q.size() != 0) begin
        w = exp_wr_q.pop_front();
      end
      if (rd_req_en) begin
        if (exp_rd_q.size() == 0) begin
          check("read_expected", 32'(exp_rd_q.size()), 32'd1);
        end else begin
          r = exp_rd_q.pop_front();
          check("rd_data", 32'(rd_data), 32'(r[7:0]));
          check("rd_fwd", 32'(rd_fwd), 32'(r[8]));
        end
      end else begin
        check("rd_idle", 32'({rd_fwd, rd_data}), 32'd0);
      end
      check("rd_passthru", 32'({mem_read_enable, mem_read_adr}), 32'({rd_req_en, rd_req_adr}));
    end
  end

  // ---------------- driver tasks ----------------
  // One clock cycle: drive inputs just after an edge, predict this cycle's
  // outputs, then advance the model across the next edge.
  task automatic cycle(input bit we, input logic [5:0] wa, input logic [7:0] wd,
                       input bit re, input logic [5:0] ra);
    bit         coal_hit;
    int         coal_i;
    bit         alloc;
    bit         acc;
    bit         fwd;
    logic [7:0] rv;
    ent_t       e;
    wr_req_en   = we;
    wr_req_adr  = wa;
    wr_req_data = wd;
    rd_req_en   = re;
    rd_req_adr  = ra;
    coal_hit = 1'b0;
    coal_i   = 0;
    if (COAL && we) begin
      for (int i = 1; i < mdl_q.size(); i++) begin
        if (mdl_q[i].adr == wa) begin
          coal_hit = 1'b1;
          coal_i   = i;
        end
      end
    end
    alloc = we && !coal_hit && (mdl_q.size() < DEPTH);
    acc   = coal_hit || alloc;
    exp_st_q.push_back({mdl_sv, mdl_q.size() == DEPTH, (mdl_q.size() == 0) && !mdl_sv});
    if (re) begin
      fwd = 1'b1;
      rv  = 8'h00;
      if (acc && wa == ra) begin
        rv = wd;
      end else begin
        bit found;
        found = 1'b0;
        for (int i = mdl_q.size() - 1; i >= 0; i--) begin
          if (!found && mdl_q[i].adr == ra) begin
            found = 1'b1;
            rv    = mdl_q[i].data;
          end
        end
        if (!found) begin
          if (mdl_sv && mdl_sa == ra) begin
            rv = mdl_sd;
          end else begin
            rv  = mdl_ram[ra];
            fwd = 1'b0;
          end
        end
      end
      exp_rd_q.push_back({fwd, rv});
    end
    @(posedge clk);
    #1;
    if (mdl_sv) mdl_ram[mdl_sa] = mdl_sd;
    if (coal_hit) mdl_q[coal_i].data = wd;
    if (mdl_q.size() > 0) begin
      e      = mdl_q.pop_front();
      mdl_sv = 1'b1;
      mdl_sa = e.adr;
      mdl_sd = e.data;
      exp_wr_q.push_back({e.adr, e.data});
    end else begin
      mdl_sv = 1'b0;
    end
    if (alloc) mdl_q.push_back('{adr: wa, data: wd});
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 6'd0, 8'd0, 1'b0, 6'd0);
  endtask

  // Reset discards everything queued or in flight; RAM contents are kept.
  task automatic do_reset(input int n);
    reset     = 1'b0;
    wr_req_en = 1'b0;
    rd_req_en = 1'b0;
    mdl_q.delete();
    mdl_sv = 1'b0;
    exp_wr_q.delete();
    exp_rd_q.delete();
    repeat (n) begin
      exp_st_q.push_back(3'b001);
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    total = 0;
    bad   = 0;
    mon_on = 1'b0;
    mdl_sv = 1'b0;
    mdl_sa = '0;
    mdl_sd = '0;
    for (int i = 0; i < 64; i++) begin
      env_ram[i] = 8'($urandom_range(0, 255));
      mdl_ram[i] = env_ram[i];
    end
    reset       = 1'b0;
    wr_req_en   = 1'b0;
    wr_req_adr  = '0;
    wr_req_data = '0;
    rd_req_en   = 1'b0;
    rd_req_adr  = '0;
    repeat (2) @(posedge clk);
    #1;
    mon_on = 1'b1;
    do_reset(2);

    // single write drains after one cycle
    cycle(1'b1, 6'h05, 8'hA5, 1'b0, 6'h00);
    idle(3);

    // back-to-back pushes then a push to 0x3F
    cycle(1'b1, 6'h01, 8'h10, 1'b0, 6'h00);
    cycle(1'b1, 6'h02, 8'h20, 1'b0, 6'h00);
    cycle(1'b1, 6'h03, 8'h30, 1'b0, 6'h00);
    cycle(1'b1, 6'h04, 8'h40, 1'b0, 6'h00);
    cycle(1'b1, 6'h3F, 8'h11, 1'b1, 6'h3F);
    idle(3);

    // forward from buffer, then from RAM after commit
    cycle(1'b1, 6'h10, 8'h22, 1'b0, 6'h00);
    cycle(1'b0, 6'h00, 8'h00, 1'b1, 6'h10);
    cycle(1'b0, 6'h00, 8'h00, 1'b1, 6'h10);
    idle(2);
    cycle(1'b0, 6'h00, 8'h00, 1'b1, 6'h10);

    // same address written twice, then read
    cycle(1'b1, 6'h08, 8'h01, 1'b0, 6'h00);
    cycle(1'b1, 6'h08, 8'h02, 1'b0, 6'h00);
    cycle(1'b0, 6'h00, 8'h00, 1'b1, 6'h08);
    idle(3);
    cycle(1'b0, 6'h00, 8'h00, 1'b1, 6'h08);

    // same-cycle push and read
    cycle(1'b1, 6'h2A, 8'h77, 1'b1, 6'h2A);
    idle(3);

    // reset in the middle of a drain
    cycle(1'b1, 6'h11, 8'h5A, 1'b0, 6'h00);
    cycle(1'b1, 6'h12, 8'h5B, 1'b0, 6'h00);
    cycle(1'b1, 6'h13, 8'h5C, 1'b0, 6'h00);
    do_reset(1);
    cycle(1'b0, 6'h00, 8'h00, 1'b1, 6'h13);
    idle(2);

    // random traffic concentrated on a few addresses to provoke hits
    for (int n = 0; n < 3000; n++) begin
      bit         we;
      bit         re;
      logic [5:0] wa;
      logic [5:0] ra;
      logic [7:0] wd;
      if ($urandom_range(0, 599) == 0) begin
        do_reset(1);
      end else begin
        we = ($urandom_range(0, 3) != 0);
        re = ($urandom_range(0, 2) != 0);
        wa = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 7));
        ra = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 7));
        wd = 8'($urandom_range(0, 255));
        cycle(we, wa, wd, re, ra);
      end
    end
    idle(4);
    mon_on = 1'b0;

    check("ram_writes_left", 32'(exp_wr_q.size()), 32'd0);
    check("reads_left", 32'(exp_rd_q.size()), 32'd0);
    for (int i = 0; i < 64; i++) begin
      if (env_ram[i] !== mdl_ram[i]) check("ram_final", 32'(env_ram[i]), 32'(mdl_ram[i]));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
